riscv_imm_unit: RTL and testbench

- Registered immediate generator for the RV32I decode stage.
- Takes instruction bits [31:7] plus a 3-bit format select, and returns the sign-extended 32-bit immediate one clock later.
- Output is qualified by a valid flag.
- Feeds the ALU B-operand mux and the branch/jump target adder.

---
 rtl/riscv_imm_unit.sv | 67 ++++++
 tb/tb_riscv_imm_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/riscv_imm_unit.sv
// Registered RV32I immediate generator: decodes instruction bits [31:7] per format into a 32-bit immediate.
// Optional RISCV_IMM_UNIT_ILLEGAL_DET_EN registers an illegal flag for unused format codes; otherwise illegal is 0.
module riscv_imm_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [24:0] imm,
  input  logic [2:0]  immsrc,
  output logic [31:0] immext,
  output logic        out_valid,
  output logic        illegal
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_U = 3'b010;
  localparam logic [2:0] FMT_B = 3'b101;
  localparam logic [2:0] FMT_J = 3'b110;

  logic        sign;
  logic [31:0] next_imm;

  assign sign = imm[24];

  // Field shuffle and sign replication only; unused codes yield zero.
  always_comb begin
    next_imm = 32'h0000_0000;
    case (immsrc)
      FMT_I:   next_imm = {{20{sign}}, imm[24:13]};
      FMT_S:   next_imm = {{20{sign}}, imm[24:18], imm[4:0]};
      FMT_B:   next_imm = {{19{sign}}, sign, imm[0], imm[23:18], imm[4:1], 1'b0};
      FMT_U:   next_imm = {imm[24:5], 12'h000};
      FMT_J:   next_imm = {{11{sign}}, sign, imm[12:5], imm[13], imm[23:14], 1'b0};
      default: next_imm = 32'h0000_0000;
    endcase
  end

  // immext holds its last value while in_valid is low; out_valid tracks the capture strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      immext    <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        immext <= next_imm;
      end
    end
  end

`ifdef RISCV_IMM_UNIT_ILLEGAL_DET_EN
  logic unused_code;

  assign unused_code = !(immsrc inside {FMT_I, FMT_S, FMT_U, FMT_B, FMT_J});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (in_valid) begin
      illegal <= unused_code;
    end
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_imm_unit.sv
// Self-checking bench for riscv_imm_unit: directed vectors, reset/hold behaviour, then random
// traffic checked against an instruction-field reference model.
module tb_riscv_imm_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [24:0] imm;
  logic [2:0]  immsrc;
  logic [31:0] immext;
  logic        out_valid;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_immext = 32'h0;
  logic        exp_valid  = 1'b0;
  logic        exp_ill    = 1'b0;

  riscv_imm_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .imm       (imm),
    .immsrc    (immsrc),
    .immext    (immext),
    .out_valid (out_valid),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rebuild the instruction word and apply the architectural immediate definitions.
  function automatic logic [31:0] ref_imm(input logic [24:0] f, input logic [2:0] src);
    logic [31:0] ins;
    ins = {f, 7'b0000000};
    case (src)
      3'b000:  return 32'($signed(ins[31:20]));
      3'b001:  return 32'($signed({ins[31:25], ins[11:7]}));
      3'b101:  return 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'b010:  return {ins[31:12], 12'h000};
      3'b110:  return 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [2:0] src);
`ifdef RISCV_IMM_UNIT_ILLEGAL_DET_EN
    return (src == 3'b011) || (src == 3'b100) || (src == 3'b111);
`else
    return (src == 3'b111) && 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".immext"}, immext, exp_immext);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
  endtask

  // Drive at negedge, clock once, update the model, compare after the edge.
  task automatic step(input string tag, input logic v, input logic [24:0] f, input logic [2:0] src);
    @(negedge clk);
    in_valid = v;
    imm      = f;
    immsrc   = src;
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) begin
      exp_immext = ref_imm(f, src);
      exp_ill    = ref_illegal(src);
    end
    chk_all(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    imm      = '0;
    immsrc   = 3'b000;
    #12;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("i_pos", 1'b1, 25'b0001000000110000000000101, 3'b000);
    chk("i_pos.const", immext, 32'h0000_0103);
    step("i_neg", 1'b1, 25'b1110111111010000000000101, 3'b000);
    chk("i_neg.const", immext, 32'hFFFF_FEFD);
    step("s", 1'b1, 25'b0000011001010001001001001, 3'b001);
    chk("s.const", immext, 32'h0000_0069);
    step("b", 1'b1, 25'b0000000000000010110110000, 3'b101);
    chk("b.const", immext, 32'h0000_0010);
    step("u", 1'b1, 25'b0000000001011111010000101, 3'b010);
    chk("u.const", immext, 32'h005F_4000);
    step("j", 1'b1, 25'b1111110111011111111100001, 3'b110);
    chk("j.const", immext, 32'hFFFF_FFDC);
    step("unused111", 1'b1, 25'h1FF_FFFF, 3'b111);
    chk("unused111.const", immext, 32'h0000_0000);
    step("j_again", 1'b1, 25'b1111110111011111111100001, 3'b110);
    step("hold", 1'b0, 25'h0AB_CDEF, 3'b000);
    chk("hold.const", immext, 32'hFFFF_FFDC);
    step("hold2", 1'b0, 25'h155_5555, 3'b010);

    // Asynchronous reset between edges while a capture is pending.
    step("pre_rst", 1'b1, 25'h123_4567, 3'b001);
    @(negedge clk);
    in_valid = 1'b1;
    imm      = 25'h1AB_CDEF;
    immsrc   = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    exp_immext = 32'h0; exp_valid = 1'b0; exp_ill = 1'b0;
    chk_all("async_rst");
    @(posedge clk);
    #1;
    chk_all("rst_held");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst_idle");
    step("post_rst_cap", 1'b1, 25'b0001000000110000000000101, 3'b000);

    for (int n = 0; n < 300; n++) begin
      step("rand", ($urandom_range(0, 3) != 0), 25'($urandom), 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
